// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Requester ids double as the round-robin pointer encoding.
package rf_write_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rf_wr_hold.sv
// One-entry writeback holding buffer.
// A load takes priority over a clear so a draining entry can be refilled.
module rf_wr_hold
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load.
// Define RF_ARB_R0_DROP_EN to silently discard writes to register 0.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 write_EN,
  output logic [ADDR_W-1:0]    reg_write_add,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic              hold_a_valid;
  logic [ADDR_W-1:0] hold_a_addr;
  logic [DATA_W-1:0] hold_a_data;
  logic              hold_b_valid;
  logic [ADDR_W-1:0] hold_b_addr;
  logic [DATA_W-1:0] hold_b_data;

  req_id_t rr_ptr;
  req_id_t grant_id;
  logic    any_grant;
  logic    grant_a;
  logic    grant_b;
  logic    keep_a;
  logic    keep_b;
  logic    load_a;
  logic    load_b;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant depends only on registered state, keeping ready free of valid.
  always_comb begin
    any_grant = 1'b0;
    grant_id  = REQ_A;
    if (hold_a_valid && hold_b_valid) begin
      any_grant = 1'b1;
      grant_id  = rr_ptr;
    end else if (hold_a_valid) begin
      any_grant = 1'b1;
      grant_id  = REQ_A;
    end else if (hold_b_valid) begin
      any_grant = 1'b1;
      grant_id  = REQ_B;
    end
  end

  assign grant_a = any_grant && (grant_id == REQ_A);
  assign grant_b = any_grant && (grant_id == REQ_B);

  assign a_ready = ~hold_a_valid | grant_a;
  assign b_ready = ~hold_b_valid | grant_b;

`ifdef RF_ARB_R0_DROP_EN
  assign keep_a = (a_addr != '0);
  assign keep_b = (b_addr != '0);
`else
  assign keep_a = 1'b1;
  assign keep_b = 1'b1;
`endif

  assign load_a = a_valid && a_ready && keep_a;
  assign load_b = b_valid && b_ready && keep_b;

  rf_wr_hold #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold_a (
    .clk     (clk),
    .rst     (rst),
    .load    (load_a),
    .clear   (grant_a),
    .in_addr (a_addr),
    .in_data (a_data),
    .valid   (hold_a_valid),
    .addr    (hold_a_addr),
    .data    (hold_a_data)
  );

  rf_wr_hold #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold_b (
    .clk     (clk),
    .rst     (rst),
    .load    (load_b),
    .clear   (grant_b),
    .in_addr (b_addr),
    .in_data (b_data),
    .valid   (hold_b_valid),
    .addr    (hold_b_addr),
    .data    (hold_b_data)
  );

  assign sel_addr = grant_b ? hold_b_addr : hold_a_addr;
  assign sel_data = grant_b ? hold_b_data : hold_a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= REQ_A;
    end else if (any_grant) begin
      rr_ptr <= (grant_id == REQ_A) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_EN       <= 1'b0;
      reg_write_add  <= '0;
      reg_write_data <= '0;
    end else begin
      write_EN <= any_grant;
      if (any_grant) begin
        reg_write_add  <= sel_addr;
        reg_write_data <= sel_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (hold_a_valid) pending[hold_a_addr] = 1'b1;
    if (hold_b_valid) pending[hold_b_addr] = 1'b1;
    if (write_EN)     pending[reg_write_add] = 1'b1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter.
// Reference model: per-requester entry queues, a turn flag and a register array.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          write_EN;
  logic [AW-1:0] reg_write_add;
  logic [DW-1:0] reg_write_data;
  logic [NR-1:0] pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_addr         (a_addr),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_addr         (b_addr),
    .b_data         (b_data),
    .write_EN       (write_EN),
    .reg_write_add  (reg_write_add),
    .reg_write_data (reg_write_data),
    .pending        (pending)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          qa[$];
  ent_t          qb[$];
  bit            turn_b;
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rf [NR] = '{default: '0};
  logic [DW-1:0] tb_rf [NR] = '{default: '0};
  bit            mg_a, mg_b, mr_a, mr_b;

  function automatic bit m_grant_a();
    return qa.size() != 0 && (qb.size() == 0 || !turn_b);
  endfunction

  function automatic bit m_grant_b();
    return qb.size() != 0 && (qa.size() == 0 || turn_b);
  endfunction

  function automatic bit exp_ra();
    return qa.size() == 0 || m_grant_a();
  endfunction

  function automatic bit exp_rb();
    return qb.size() == 0 || m_grant_b();
  endfunction

  function automatic bit dropped(logic [AW-1:0] ad);
`ifdef RF_ARB_R0_DROP_EN
    return ad == '0;
`else
    return ad != ad;
`endif
  endfunction

  function automatic logic [NR-1:0] exp_pending();
    logic [NR-1:0] p;
    p = '0;
    foreach (qa[i]) p[qa[i].addr] = 1'b1;
    foreach (qb[i]) p[qb[i].addr] = 1'b1;
    if (m_we) p[m_wa] = 1'b1;
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      turn_b = 1'b0;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      mg_a = m_grant_a();
      mg_b = m_grant_b();
      mr_a = exp_ra();
      mr_b = exp_rb();
      if (m_we) m_rf[m_wa] = m_wd;
      m_we = mg_a || mg_b;
      if (mg_a) begin
        m_wa = qa[0].addr;
        m_wd = qa[0].data;
        void'(qa.pop_front());
        turn_b = 1'b1;
      end else if (mg_b) begin
        m_wa = qb[0].addr;
        m_wd = qb[0].data;
        void'(qb.pop_front());
        turn_b = 1'b0;
      end
      if (a_valid && mr_a && !dropped(a_addr))
        qa.push_back(ent_t'{addr: a_addr, data: a_data});
      if (b_valid && mr_b && !dropped(b_addr))
        qb.push_back(ent_t'{addr: b_addr, data: b_data});
    end
  end

  always @(posedge clk) begin
    if (write_EN) tb_rf[reg_write_add] <= reg_write_data;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (write_EN !== 1'b0 || pending !== '0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_init: we=%b pend=%h ra=%b rb=%b want 0 00 1 1",
               write_EN, pending, a_ready, b_ready);
    end
    step();
    rst = 1'b0;
    step();
    a_valid = 1'b1; a_addr = 3'd4; a_data = 16'h4444;
    b_valid = 1'b1; b_addr = 3'd6; b_data = 16'h6666;
    step();
    idle_inputs();
    tests++;
    if (pending !== 8'h50) begin
      fails++;
      $display("FAIL reset_fill: pend=%h want 50", pending);
    end
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (write_EN !== 1'b0 || pending !== '0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_async: we=%b pend=%h ra=%b rb=%b want 0 00 1 1",
               write_EN, pending, a_ready, b_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (write_EN !== 1'b0 || pending !== '0) begin
        fails++;
        $display("FAIL reset_release: we=%b pend=%h want 0 00", write_EN, pending);
      end
    end
    tests++;
    if (tb_rf[4] !== 16'h0 || tb_rf[6] !== 16'h0) begin
      fails++;
      $display("FAIL reset_nocommit: r4=%h r6=%h want 0 0", tb_rf[4], tb_rf[6]);
    end
  endtask

  task automatic test_a_only();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
    step();
    idle_inputs();
    tests++;
    if (write_EN !== 1'b0 || pending !== 8'h08) begin
      fails++;
      $display("FAIL a_only_e0: we=%b pend=%h want 0 08", write_EN, pending);
    end
    step();
    tests++;
    if (write_EN !== 1'b1 || reg_write_add !== 3'd3 ||
        reg_write_data !== 16'h1234 || pending !== 8'h08) begin
      fails++;
      $display("FAIL a_only_e1: we=%b add=%0d data=%h pend=%h want 1 3 1234 08",
               write_EN, reg_write_add, reg_write_data, pending);
    end
    step();
    tests++;
    if (write_EN !== 1'b0 || pending !== '0 || tb_rf[3] !== 16'h1234) begin
      fails++;
      $display("FAIL a_only_e2: we=%b pend=%h r3=%h want 0 00 1234",
               write_EN, pending, tb_rf[3]);
    end
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 16'hBBBB;
    step();
    idle_inputs();
    step();
    tests++;
    if (write_EN !== 1'b1 || reg_write_add !== 3'd1 ||
        reg_write_data !== 16'hAAAA || pending !== 8'h06) begin
      fails++;
      $display("FAIL contend_first: we=%b add=%0d data=%h pend=%h want 1 1 aaaa 06",
               write_EN, reg_write_add, reg_write_data, pending);
    end
    step();
    tests++;
    if (write_EN !== 1'b1 || reg_write_add !== 3'd2 ||
        reg_write_data !== 16'hBBBB || pending !== 8'h04) begin
      fails++;
      $display("FAIL contend_second: we=%b add=%0d data=%h pend=%h want 1 2 bbbb 04",
               write_EN, reg_write_add, reg_write_data, pending);
    end
    step();
    tests++;
    if (write_EN !== 1'b0 || pending !== '0 || dut.rr_ptr !== REQ_A) begin
      fails++;
      $display("FAIL contend_end: we=%b pend=%h rr=%b want 0 00 0",
               write_EN, pending, dut.rr_ptr);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd7; a_data = 16'h0777;
    step();
    idle_inputs();
    step();
    step();
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h0001;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 16'h0002;
    step();
    idle_inputs();
    step();
    tests++;
    if (write_EN !== 1'b1 || reg_write_data !== 16'h0002 || pending[5] !== 1'b1) begin
      fails++;
      $display("FAIL same_first: we=%b data=%h p5=%b want 1 0002 1",
               write_EN, reg_write_data, pending[5]);
    end
    step();
    tests++;
    if (write_EN !== 1'b1 || reg_write_data !== 16'h0001 || pending[5] !== 1'b1) begin
      fails++;
      $display("FAIL same_second: we=%b data=%h p5=%b want 1 0001 1",
               write_EN, reg_write_data, pending[5]);
    end
    step();
    tests++;
    if (pending[5] !== 1'b0 || tb_rf[5] !== 16'h0001) begin
      fails++;
      $display("FAIL same_final: p5=%b r5=%h want 0 0001", pending[5], tb_rf[5]);
    end
  endtask

  task automatic test_back_to_back();
    int ia, ib, cyc, first, last;
    bit acc_a, acc_b;
    logic [DW-1:0] got[$];
    logic [DW-1:0] want;
    do_reset();
    ia = 0; ib = 0; cyc = 0; first = -1; last = -1;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hA000;
    b_valid = 1'b1; b_addr = 3'd1; b_data = 16'hB000;
    while (cyc < 80 && !(got.size() == 16 && ia == 8 && ib == 8)) begin
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      step();
      cyc++;
      if (acc_a) ia++;
      if (acc_b) ib++;
      a_valid = (ia < 8);
      b_valid = (ib < 8);
      a_addr  = AW'(1 + ia % 7);
      b_addr  = AW'(1 + ib % 7);
      a_data  = 16'hA000 | DW'(ia);
      b_data  = 16'hB000 | DW'(ib);
      if (write_EN) begin
        got.push_back(reg_write_data);
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    idle_inputs();
    tests++;
    if (got.size() != 16 || last - first + 1 != 16) begin
      fails++;
      $display("FAIL b2b_count: writes=%0d span=%0d want 16 16",
               got.size(), last - first + 1);
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      want = ((k % 2) == 0) ? (16'hA000 | DW'(k / 2)) : (16'hB000 | DW'(k / 2));
      tests++;
      if (got[k] !== want) begin
        fails++;
        $display("FAIL b2b_order[%0d]: got %h want %h", k, got[k], want);
      end
    end
  endtask

  task automatic test_r0();
    bit drop_on;
    drop_on = dropped(3'd0);
    do_reset();
    a_valid = 1'b1; a_addr = 3'd0; a_data = 16'hFFFF;
    step();
    idle_inputs();
    tests++;
    if (pending[0] !== !drop_on) begin
      fails++;
      $display("FAIL r0_pending: p0=%b want %b", pending[0], !drop_on);
    end
    step();
    tests++;
    if (write_EN !== !drop_on || (!drop_on &&
        (reg_write_add !== 3'd0 || reg_write_data !== 16'hFFFF))) begin
      fails++;
      $display("FAIL r0_write: we=%b add=%0d data=%h want we=%b",
               write_EN, reg_write_add, reg_write_data, !drop_on);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tests++;
      if (a_ready !== exp_ra() || b_ready !== exp_rb()) begin
        fails++;
        $display("FAIL rand_ready c%0d: ra=%b rb=%b want %b %b",
                 c, a_ready, b_ready, exp_ra(), exp_rb());
      end
      tests++;
      if (write_EN !== m_we || reg_write_add !== m_wa || reg_write_data !== m_wd) begin
        fails++;
        $display("FAIL rand_write c%0d: we=%b add=%0d data=%h want %b %0d %h",
                 c, write_EN, reg_write_add, reg_write_data, m_we, m_wa, m_wd);
      end
      tests++;
      if (pending !== exp_pending()) begin
        fails++;
        $display("FAIL rand_pending c%0d: pend=%h want %h", c, pending, exp_pending());
      end
      a_valid = ($urandom_range(0, 99) < 60);
      b_valid = ($urandom_range(0, 99) < 60);
      a_addr  = AW'($urandom_range(0, NR - 1));
      b_addr  = AW'($urandom_range(0, NR - 1));
      a_data  = DW'($urandom);
      b_data  = DW'($urandom);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    for (int r = 0; r < NR; r++) begin
      tests++;
      if (tb_rf[r] !== m_rf[r]) begin
        fails++;
        $display("FAIL rand_rf[%0d]: got %h want %h", r, tb_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_same_addr();
    test_back_to_back();
    test_r0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
